// File: rtl/acc_pkg.sv
// Shared constants and types for the accelerator output path.
// The datapath and acc_out_wrapper both import this package.
package acc_pkg;

    localparam int ACC_DATA_W       = 21;
    localparam int ACC_OUT_DEPTH    = 8;
    localparam int ACC_OUT_ADDR_W   = $clog2(ACC_OUT_DEPTH);
    localparam int ACC_OUT_CNT_W    = ACC_OUT_ADDR_W + 1;
    localparam int ACC_OUT_AF_LEVEL = 6;

    typedef logic [ACC_DATA_W-1:0]    acc_word_t;
    typedef logic [ACC_OUT_CNT_W-1:0] acc_cnt_t;

    // Net effect of one edge on the FIFO occupancy.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } acc_out_op_e;

    function automatic acc_out_op_e acc_out_op(input logic push, input logic pop);
        acc_out_op_e op;
        case ({pop, push})
            2'b01:   op = OP_PUSH;
            2'b10:   op = OP_POP;
            2'b11:   op = OP_BOTH;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/acc_out_wrapper_if.sv
// Bundle of the write, read-handshake and status signals of acc_out_wrapper.
// almost_full and its modport entries exist only with ACC_OUT_ALMOST_FULL_EN.
interface acc_out_wrapper_if;
    import acc_pkg::*;

    logic      wr_req;
    acc_word_t wr_data;
    logic      full;
    logic      empty;
    acc_cnt_t  count;
    logic      out_valid;
    acc_word_t out_data;
    logic      out_ready;
    logic      overflow;
`ifdef ACC_OUT_ALMOST_FULL_EN
    logic      almost_full;

    modport slave (
        input  wr_req, wr_data, out_ready,
        output full, empty, count, out_valid, out_data, overflow, almost_full
    );

    modport master (
        output wr_req, wr_data, out_ready,
        input  full, empty, count, out_valid, out_data, overflow, almost_full
    );
`else
    modport slave (
        input  wr_req, wr_data, out_ready,
        output full, empty, count, out_valid, out_data, overflow
    );

    modport master (
        output wr_req, wr_data, out_ready,
        input  full, empty, count, out_valid, out_data, overflow
    );
`endif
endinterface

// File: rtl/acc_out_ram.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Contents are deliberately not reset; the wrapper never exposes stale words as valid.
module acc_out_ram #(
    parameter int DATA_W = 21,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Store the incoming word at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/acc_out_wrapper.sv
// First-word-fall-through result FIFO between the accelerator datapath and its consumer.
// Optional macro ACC_OUT_ALMOST_FULL_EN adds the almost_full status output.
module acc_out_wrapper
    import acc_pkg::*;
#(
    parameter int DATA_W   = ACC_DATA_W,
    parameter int DEPTH    = ACC_OUT_DEPTH,
`ifdef ACC_OUT_ALMOST_FULL_EN
    parameter int ADDR_W   = ACC_OUT_ADDR_W,
    parameter int AF_LEVEL = ACC_OUT_AF_LEVEL
`else
    parameter int ADDR_W   = ACC_OUT_ADDR_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    acc_out_wrapper_if.slave   bus
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    acc_out_op_e       op_s;
    logic [DATA_W-1:0] head_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == CNT_ZERO);

    // A write on a full cycle is dropped even if the consumer pops on the same edge.
    assign push_s = bus.wr_req & ~full_s;
    assign pop_s  = ~empty_s & bus.out_ready;
    assign drop_s = bus.wr_req & full_s;
    assign op_s   = acc_out_op(push_s, pop_s);

    acc_out_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    // Pointers and occupancy; pointers wrap by natural ADDR_W-bit rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case (op_s)
                OP_PUSH: count_r <= count_r + CNT_ONE;
                OP_POP:  count_r <= count_r - CNT_ONE;
                OP_BOTH: count_r <= count_r;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign bus.full      = full_s;
    assign bus.empty     = empty_s;
    assign bus.count     = count_r;
    assign bus.out_valid = ~empty_s;
    assign bus.out_data  = head_s;
    assign bus.overflow  = overflow_r;

`ifdef ACC_OUT_ALMOST_FULL_EN
    assign bus.almost_full = (count_r >= CNT_W'(AF_LEVEL));
`endif

endmodule

// File: tb/tb_acc_out_wrapper.sv
// Self-checking bench for acc_out_wrapper: directed scenarios plus random traffic
// against a queue-based reference model of the FIFO.
module tb_acc_out_wrapper;
    import acc_pkg::*;

    localparam int MODEL_DEPTH = 8;
    localparam int MODEL_AF    = 6;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [20:0] model_q[$];
    logic        model_ovf;

    acc_out_wrapper_if bus ();

    acc_out_wrapper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = model_q.size();
        check("count", 32'(bus.count), 32'(sz));
        check("empty", 32'(bus.empty), 32'(sz == 0));
        check("full", 32'(bus.full), 32'(sz == MODEL_DEPTH));
        check("out_valid", 32'(bus.out_valid), 32'(sz != 0));
        check("overflow", 32'(bus.overflow), 32'(model_ovf));
        if (sz != 0) begin
            check("out_data", 32'(bus.out_data), 32'(model_q[0]));
        end
`ifdef ACC_OUT_ALMOST_FULL_EN
        check("almost_full", 32'(bus.almost_full), 32'(sz >= MODEL_AF));
`endif
    endtask

    // Drive one cycle of inputs, advance the model by the same edge, then check.
    task automatic cycle(input logic wr, input logic [20:0] data, input logic rdy, input logic rs);
        bit was_full;
        bit do_pop;
        rst           = rs;
        bus.wr_req    = wr;
        bus.wr_data   = data;
        bus.out_ready = rdy;
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            was_full = (model_q.size() == MODEL_DEPTH);
            do_pop   = rdy && (model_q.size() != 0);
            if (do_pop) void'(model_q.pop_front());
            if (wr && !was_full) model_q.push_back(data);
            if (wr && was_full) model_ovf = 1'b1;
        end
        #1;
        check_state();
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        model_ovf     = 1'b0;
        rst           = 1'b1;
        bus.wr_req    = 1'b0;
        bus.wr_data   = 21'h0;
        bus.out_ready = 1'b0;

        // Reset then idle.
        cycle(1'b0, 21'h0, 1'b0, 1'b1);
        check("rst_empty", 32'(bus.empty), 32'd1);
        cycle(1'b0, 21'h0, 1'b0, 1'b0);

        // Single word, then consume it.
        cycle(1'b1, 21'h0ABCDE, 1'b0, 1'b0);
        check("single_data", 32'(bus.out_data), 32'h0ABCDE);
        cycle(1'b0, 21'h0, 1'b1, 1'b0);
        check("single_drained", 32'(bus.empty), 32'd1);
        cycle(1'b0, 21'h0, 1'b1, 1'b0);

        // Fill past capacity, then drain in order.
        for (int i = 1; i <= 9; i++) cycle(1'b1, 21'(i), 1'b0, 1'b0);
        check("fill_count", 32'(bus.count), 32'd8);
        check("fill_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", 32'(bus.out_data), 32'(i));
            cycle(1'b0, 21'h0, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Streaming through the pointer wrap with the consumer always ready.
        cycle(1'b0, 21'h0, 1'b0, 1'b1);
        for (int i = 100; i < 120; i++) begin
            cycle(1'b1, 21'(i), 1'b1, 1'b0);
            check("stream_le1", 32'(bus.count <= 4'd1), 32'd1);
        end
        cycle(1'b0, 21'h0, 1'b1, 1'b0);

        // Simultaneous push and pop at count==1.
        cycle(1'b1, 21'd5, 1'b0, 1'b0);
        cycle(1'b1, 21'd6, 1'b1, 1'b0);
        check("pp_count", 32'(bus.count), 32'd1);
        check("pp_head", 32'(bus.out_data), 32'd6);

        // Push on a full cycle while popping: the write is dropped.
        for (int i = 0; i < 7; i++) cycle(1'b1, 21'(200 + i), 1'b0, 1'b0);
        cycle(1'b1, 21'h1FFFFF, 1'b1, 1'b0);
        check("full_pp_count", 32'(bus.count), 32'd7);
        check("full_pp_ovf", 32'(bus.overflow), 32'd1);

        // Reset wins over a simultaneous push and pop.
        cycle(1'b0, 21'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 21'(300 + i), 1'b0, 1'b0);
        cycle(1'b1, 21'h12345, 1'b1, 1'b1);
        check("rst_mid_count", 32'(bus.count), 32'd0);
        check("rst_mid_ovf", 32'(bus.overflow), 32'd0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 99) < 55), 21'($urandom), ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 299) == 0));
        end
        for (int n = 0; n < 10; n++) cycle(1'b0, 21'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
